// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I/D memory arbiter: FSM state and grant encodings,
// default parameter values and a counter-width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arbState_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  localparam int DEFAULT_MAX_WAIT    = 4;
  localparam int DEFAULT_RAM_LATENCY = 1;

  // Bits needed to hold 0..maxValue, never less than one bit.
  function automatic int minWidth(input int maxValue);
    return (maxValue > 1) ? $clog2(maxValue + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of consecutive arbitrations the fetch port lost to the data port.
// at_max_o tells the arbiter that fetch must win the next tie.
module mem_arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CNT_W = minWidth(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port synchronous RAM.
// Data port has priority; the fetch port is forced through after MAX_WAIT consecutive losses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = DEFAULT_RAM_LATENCY,
  parameter int MAX_WAIT    = DEFAULT_MAX_WAIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_mask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                m_en,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_mask,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int LAT_W = minWidth(RAM_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LATENCY - 1);

  arbState_e           state_q, state_d;
  grant_e              grant_q, grant_d;
  logic [LAT_W-1:0]    latCnt_q, latCnt_d;
  logic                mEn_q, mEn_d;
  logic                mWe_q, mWe_d;
  logic [DATA_W/8-1:0] mMask_q, mMask_d;
  logic [ADDR_W-1:0]   mAddr_q, mAddr_d;
  logic [DATA_W-1:0]   mWdata_q, mWdata_d;
  logic                iAck_q, iAck_d;
  logic                dAck_q, dAck_d;

  logic isIdle;
  logic anyReq;
  logic pickI;
  logic starveInc;
  logic starveClr;
  logic starveAtMax;

  // Fetch wins when it is alone or when it has already lost MAX_WAIT ties in a row.
  assign isIdle    = (state_q == ARB_IDLE);
  assign anyReq    = i_req | d_req;
  assign pickI     = i_req & (~d_req | starveAtMax);
  assign starveInc = isIdle & i_req & d_req & ~pickI;
  assign starveClr = isIdle & pickI;

  mem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starveCnt (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (starveInc),
    .clr_i    (starveClr),
    .at_max_o (starveAtMax)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    latCnt_d = latCnt_q;
    mEn_d    = 1'b0;
    mWe_d    = 1'b0;
    mMask_d  = '0;
    mAddr_d  = mAddr_q;
    mWdata_d = mWdata_q;
    iAck_d   = 1'b0;
    dAck_d   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (anyReq) begin
          state_d = ARB_ISSUE;
          mEn_d   = 1'b1;
          if (pickI) begin
            grant_d = GRANT_I;
            mAddr_d = i_addr;
          end else begin
            grant_d  = GRANT_D;
            mWe_d    = d_we;
            mMask_d  = d_we ? d_mask : '0;
            mAddr_d  = d_addr;
            mWdata_d = d_wdata;
          end
        end
      end

      ARB_ISSUE: begin
        state_d  = ARB_WAIT;
        latCnt_d = LAT_INIT;
        // A one-cycle RAM delivers data in the very first WAIT cycle.
        if (LAT_INIT == '0) begin
          iAck_d = (grant_q == GRANT_I);
          dAck_d = (grant_q == GRANT_D);
        end
      end

      ARB_WAIT: begin
        if (latCnt_q == '0) begin
          state_d = ARB_IDLE;
        end else begin
          latCnt_d = latCnt_q - LAT_W'(1);
          if (latCnt_q == LAT_W'(1)) begin
            iAck_d = (grant_q == GRANT_I);
            dAck_d = (grant_q == GRANT_D);
          end
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= GRANT_I;
      latCnt_q <= '0;
      mEn_q    <= 1'b0;
      mWe_q    <= 1'b0;
      mMask_q  <= '0;
      mAddr_q  <= '0;
      mWdata_q <= '0;
      iAck_q   <= 1'b0;
      dAck_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      latCnt_q <= latCnt_d;
      mEn_q    <= mEn_d;
      mWe_q    <= mWe_d;
      mMask_q  <= mMask_d;
      mAddr_q  <= mAddr_d;
      mWdata_q <= mWdata_d;
      iAck_q   <= iAck_d;
      dAck_q   <= dAck_d;
    end
  end

  assign m_en    = mEn_q;
  assign m_we    = mWe_q;
  assign m_mask  = mMask_q;
  assign m_addr  = mAddr_q;
  assign m_wdata = mWdata_q;
  assign i_ack   = iAck_q;
  assign d_ack   = dAck_q;

  // Read data is only meaningful while the matching ack is high.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with a 1-cycle RAM and MAX_WAIT=4,
// one with a 3-cycle RAM and MAX_WAIT=0, each backed by a behavioural RAM.
module tb_mem_arbiter;

  typedef struct {
    bit          isWrite;
    logic [31:0] data;
  } sbEntry_t;

  logic clk;
  logic reset;

  logic        aIReq, aIAck, aDReq, aDWe, aDAck, aMEn, aMWe;
  logic [31:0] aIAddr, aIRdata, aDAddr, aDWdata, aDRdata, aMAddr, aMWdata, aMRdata;
  logic [3:0]  aDMask, aMMask;

  logic        bIReq, bIAck, bDReq, bDWe, bDAck, bMEn, bMWe;
  logic [31:0] bIAddr, bIRdata, bDAddr, bDWdata, bDRdata, bMAddr, bMWdata, bMRdata;
  logic [3:0]  bDMask, bMMask;

  int checkCount = 0;
  int errorCount = 0;

  sbEntry_t qAI[$];
  sbEntry_t qAD[$];
  sbEntry_t qBI[$];
  sbEntry_t qBD[$];
  bit       gLogA[$];
  bit       gLogB[$];

  logic [31:0] refMem [2][256];
  logic [31:0] ramA [256];
  logic [31:0] ramB [256];
  logic [31:0] aRdPipe;
  logic [31:0] bPipe [3];
  bit          ramInit;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RAM_LATENCY(1), .MAX_WAIT(4)
  ) dutA (
    .clk(clk), .reset(reset),
    .i_req(aIReq), .i_addr(aIAddr), .i_rdata(aIRdata), .i_ack(aIAck),
    .d_req(aDReq), .d_we(aDWe), .d_mask(aDMask), .d_addr(aDAddr), .d_wdata(aDWdata),
    .d_rdata(aDRdata), .d_ack(aDAck),
    .m_en(aMEn), .m_we(aMWe), .m_mask(aMMask), .m_addr(aMAddr), .m_wdata(aMWdata),
    .m_rdata(aMRdata)
  );

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RAM_LATENCY(3), .MAX_WAIT(0)
  ) dutB (
    .clk(clk), .reset(reset),
    .i_req(bIReq), .i_addr(bIAddr), .i_rdata(bIRdata), .i_ack(bIAck),
    .d_req(bDReq), .d_we(bDWe), .d_mask(bDMask), .d_addr(bDAddr), .d_wdata(bDWdata),
    .d_rdata(bDRdata), .d_ack(bDAck),
    .m_en(bMEn), .m_we(bMWe), .m_mask(bMMask), .m_addr(bMAddr), .m_wdata(bMWdata),
    .m_rdata(bMRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    if (i == 4)  return 32'h0000_0013;
    if (i == 16) return 32'h1122_3344;
    return {8'hA5, 8'(i), 8'(~i), 8'(i * 3)};
  endfunction

  function automatic logic [31:0] mergeMask(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [3:0] mask);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = wdata[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAMs: A returns data one cycle after m_en, B three cycles after.
  always @(posedge clk) begin
    if (!ramInit) begin
      for (int i = 0; i < 256; i++) begin
        ramA[i] <= initWord(i);
        ramB[i] <= initWord(i);
      end
      ramInit <= 1'b1;
    end else begin
      if (aMEn && aMWe)
        for (int b = 0; b < 4; b++)
          if (aMMask[b]) ramA[aMAddr[9:2]][8*b +: 8] <= aMWdata[8*b +: 8];
      if (bMEn && bMWe)
        for (int b = 0; b < 4; b++)
          if (bMMask[b]) ramB[bMAddr[9:2]][8*b +: 8] <= bMWdata[8*b +: 8];
    end
    aRdPipe  <= ramA[aMAddr[9:2]];
    bPipe[0] <= ramB[bMAddr[9:2]];
    bPipe[1] <= bPipe[0];
    bPipe[2] <= bPipe[1];
  end

  assign aMRdata = aRdPipe;
  assign bMRdata = bPipe[2];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic string portName(input int idx);
    case (idx)
      0:       return "A.I";
      1:       return "A.D";
      2:       return "B.I";
      default: return "B.D";
    endcase
  endfunction

  function automatic bit ackOf(input int idx);
    case (idx)
      0:       return aIAck;
      1:       return aDAck;
      2:       return bIAck;
      default: return bDAck;
    endcase
  endfunction

  // Pops the scoreboard entry for an observed ack and compares read data.
  task automatic checkAck(input int idx, input logic [31:0] rdata, input bit prevAck);
    sbEntry_t e;
    bit       have;
    string    name;
    name = portName(idx);
    have = 1'b0;
    checkOutput({name, " ack single-cycle"}, 32'(prevAck), 32'd0);
    case (idx)
      0: if (qAI.size() > 0) begin e = qAI.pop_front(); have = 1'b1; end
      1: if (qAD.size() > 0) begin e = qAD.pop_front(); have = 1'b1; end
      2: if (qBI.size() > 0) begin e = qBI.pop_front(); have = 1'b1; end
      default: if (qBD.size() > 0) begin e = qBD.pop_front(); have = 1'b1; end
    endcase
    checkOutput({name, " ack expected"}, 32'(have), 32'd1);
    if (have && !e.isWrite) checkOutput({name, " rdata"}, rdata, e.data);
  endtask

  initial begin
    bit pAI, pAD, pBI, pBD;
    pAI = 0; pAD = 0; pBI = 0; pBD = 0;
    forever begin
      @(negedge clk);
      if (aIAck) begin checkAck(0, aIRdata, pAI); gLogA.push_back(1'b0); end
      if (aDAck) begin checkAck(1, aDRdata, pAD); gLogA.push_back(1'b1); end
      if (bIAck) begin checkAck(2, bIRdata, pBI); gLogB.push_back(1'b0); end
      if (bDAck) begin checkAck(3, bDRdata, pBD); gLogB.push_back(1'b1); end
      pAI = aIAck; pAD = aDAck; pBI = bIAck; pBD = bDAck;
    end
  end

  // Runs one transaction on port idx (0 A.I, 1 A.D, 2 B.I, 3 B.D) and holds req until ack.
  task automatic applyStimulus(input int idx, input bit we, input logic [3:0] mask,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input bit checkLat);
    sbEntry_t    e;
    int          inst, w, cycles, enCount, weCount;
    bit          seen, curEn, curWe;
    logic [3:0]  capMask;
    logic [31:0] capAddr;
    string       name;
    name = portName(idx);
    inst = idx / 2;
    w    = int'(addr[9:2]);
    if (we) begin
      refMem[inst][w] = mergeMask(refMem[inst][w], wdata, mask);
      e.isWrite = 1'b1;
      e.data    = 32'h0;
    end else begin
      e.isWrite = 1'b0;
      e.data    = refMem[inst][w];
    end
    case (idx)
      0: begin qAI.push_back(e); aIAddr = addr; aIReq = 1'b1; end
      1: begin qAD.push_back(e); aDWe = we; aDMask = mask; aDAddr = addr; aDWdata = wdata; aDReq = 1'b1; end
      2: begin qBI.push_back(e); bIAddr = addr; bIReq = 1'b1; end
      default: begin qBD.push_back(e); bDWe = we; bDMask = mask; bDAddr = addr; bDWdata = wdata; bDReq = 1'b1; end
    endcase
    cycles = 0; enCount = 0; weCount = 0; seen = 1'b0; capMask = 4'h0; capAddr = 32'h0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      curEn = (inst == 0) ? aMEn : bMEn;
      curWe = (inst == 0) ? aMWe : bMWe;
      if (curEn) begin
        enCount++;
        capMask = (inst == 0) ? aMMask : bMMask;
        capAddr = (inst == 0) ? aMAddr : bMAddr;
      end
      if (curWe) weCount++;
      if (ackOf(idx)) begin
        seen = 1'b1;
        break;
      end
      cycles++;
    end
    checkOutput({name, " ack seen"}, 32'(seen), 32'd1);
    if (checkLat) begin
      checkOutput({name, " latency"}, 32'(cycles), (inst == 0) ? 32'd2 : 32'd4);
      checkOutput({name, " m_en cycles"}, 32'(enCount), 32'd1);
      checkOutput({name, " m_we cycles"}, 32'(weCount), we ? 32'd1 : 32'd0);
      checkOutput({name, " m_mask"}, 32'(capMask), we ? 32'(mask) : 32'd0);
      checkOutput({name, " m_addr"}, capAddr, addr);
    end
    @(posedge clk);
    #1;
    case (idx)
      0: aIReq = 1'b0;
      1: aDReq = 1'b0;
      2: bIReq = 1'b0;
      default: bDReq = 1'b0;
    endcase
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      refMem[0][i] = initWord(i);
      refMem[1][i] = initWord(i);
    end
    reset = 1'b0;
    aIReq = 0; aIAddr = 0; aDReq = 0; aDWe = 0; aDMask = 0; aDAddr = 0; aDWdata = 0;
    bIReq = 0; bIAddr = 0; bDReq = 0; bDWe = 0; bDMask = 0; bDAddr = 0; bDWdata = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset A i_ack", 32'(aIAck), 32'd0);
    checkOutput("reset A d_ack", 32'(aDAck), 32'd0);
    checkOutput("reset A m_en", 32'(aMEn), 32'd0);
    checkOutput("reset A m_we", 32'(aMWe), 32'd0);
    checkOutput("reset A m_mask", 32'(aMMask), 32'd0);
    checkOutput("reset A m_addr", aMAddr, 32'd0);
    checkOutput("reset A m_wdata", aMWdata, 32'd0);
    checkOutput("reset B m_en", 32'(bMEn), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] lone fetch");
    applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b1);

    $display("[TB] masked write then reads");
    applyStimulus(1, 1'b1, 4'b0011, 32'h40, 32'hAABB_CCDD, 1'b1);
    applyStimulus(1, 1'b0, 4'hF, 32'h40, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1);
    checkOutput("write low half", {16'h0, refMem[0][16][15:0]}, 32'h0000_CCDD);

    $display("[TB] reset in WAIT");
    bDWe = 1'b0; bDAddr = 32'h84; bDReq = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0; bDReq = 1'b0;
    #1;
    checkOutput("midreset B d_ack", 32'(bDAck), 32'd0);
    checkOutput("midreset B i_ack", 32'(bIAck), 32'd0);
    checkOutput("midreset B m_en", 32'(bMEn), 32'd0);
    checkOutput("midreset B m_addr", bMAddr, 32'd0);
    checkOutput("midreset A m_addr", aMAddr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] latency-3 data port");
    applyStimulus(3, 1'b0, 4'h0, 32'h80, 32'h0, 1'b1);
    applyStimulus(3, 1'b1, 4'b1100, 32'h88, 32'h1234_5678, 1'b1);
    applyStimulus(3, 1'b0, 4'h0, 32'h88, 32'h0, 1'b1);

    $display("[TB] MAX_WAIT=0 tie");
    gLogB.delete();
    fork
      applyStimulus(2, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
      applyStimulus(3, 1'b0, 4'h0, 32'h44, 32'h0, 1'b0);
    join
    checkOutput("B tie grant count", 32'(gLogB.size()), 32'd2);
    if (gLogB.size() >= 2) begin
      checkOutput("B tie first grant", 32'(gLogB[0]), 32'd0);
      checkOutput("B tie second grant", 32'(gLogB[1]), 32'd1);
    end

    $display("[TB] contention MAX_WAIT=4");
    gLogA.delete();
    fork
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 4'h0, 32'h100 + 32'(i * 4), 32'h0, 1'b0);
      for (int j = 0; j < 12; j++) applyStimulus(1, 1'b0, 4'h0, 32'h200 + 32'(j * 4), 32'h0, 1'b0);
    join
    checkOutput("A contention grant count", 32'(gLogA.size()), 32'd15);
    for (int k = 0; k < gLogA.size(); k++)
      checkOutput($sformatf("A contention grant %0d", k), 32'(gLogA[k]), (k % 5 == 4) ? 32'd0 : 32'd1);

    repeat (6) @(posedge clk);
    #1;
    checkOutput("A.I queue drained", 32'(qAI.size()), 32'd0);
    checkOutput("A.D queue drained", 32'(qAD.size()), 32'd0);
    checkOutput("B.I queue drained", 32'(qBI.size()), 32'd0);
    checkOutput("B.D queue drained", 32'(qBD.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
